// File: rtl/fog_pkg.sv
// Shared constants and width helpers for the fragment fog stage.
package fog_pkg;

  localparam int NUM_CHANNELS    = 4;
  localparam int CH_A            = 0;
  localparam int CH_B            = 1;
  localparam int CH_G            = 2;
  localparam int CH_R            = 3;

  localparam int FOG_COORD_WIDTH = 16;
  localparam int FACTOR_WIDTH    = 16;
  localparam int LUT_DATA_WIDTH  = 32;
  localparam int LUT_A_LSB       = 16;
  localparam int LUT_B_LSB       = 0;

  function automatic int pixel_width(input int sub_pixel_width);
    return NUM_CHANNELS * sub_pixel_width;
  endfunction

  function automatic int frac_width(input int lut_size_log2);
    return FOG_COORD_WIDTH - lut_size_log2;
  endfunction

endpackage

// File: rtl/fog_lut.sv
// Fog factor table: one write port, one read-first synchronous read port.
module fog_lut
  import fog_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Reading the array before the write lands gives old data on a collision.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fragment_fog_unit.sv
// Five-stage stallable fog blend: LUT read, interpolate, weight, channel multiply, sum.
module fragment_fog_unit
  import fog_pkg::*;
#(
  parameter  int USER_WIDTH      = 1,
  parameter  int SUB_PIXEL_WIDTH = 8,
  parameter  int LUT_SIZE_LOG2   = 5,
  localparam int PIXEL_WIDTH     = pixel_width(SUB_PIXEL_WIDTH)
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic                       confEnable,
  input  logic [PIXEL_WIDTH-1:0]     confFogColor,
  input  logic                       lutWrValid,
  input  logic [LUT_SIZE_LOG2-1:0]   lutWrAddr,
  input  logic [LUT_DATA_WIDTH-1:0]  lutWrData,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [USER_WIDTH-1:0]      s_user,
  input  logic [PIXEL_WIDTH-1:0]     s_fragmentColor,
  input  logic [FOG_COORD_WIDTH-1:0] s_fogCoord,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [USER_WIDTH-1:0]      m_user,
  output logic [PIXEL_WIDTH-1:0]     m_fragmentColor
);

  localparam int SPW     = SUB_PIXEL_WIDTH;
  localparam int FRAC_W  = frac_width(LUT_SIZE_LOG2);
  localparam int PROD_W  = FACTOR_WIDTH + FRAC_W + 2;
  localparam int W_W     = SPW + 1;
  localparam int BLEND_W = 2 * SPW + 1;
  localparam int RGB_W   = 3 * SPW;
  localparam logic [W_W-1:0] W_UNITY = {1'b1, {SPW{1'b0}}};

  logic                      ce;
  logic [LUT_DATA_WIDTH-1:0] lut_rd_data;
  logic [FACTOR_WIDTH-1:0]   lut_a, lut_b;
  logic signed [PROD_W-1:0]  diff2, frac_ext2, sum3;
  logic [SPW-1:0]            f8_3;
  logic [W_W-1:0]            inv_w4;
  logic [CH_R:CH_B][BLEND_W-1:0] blend5;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d, m_valid_q, m_valid_d;
  logic en1_q, en1_d, en2_q, en2_d;
  logic [FRAC_W-1:0]       frac1_q, frac1_d;
  logic [PIXEL_WIDTH-1:0]  color1_q, color1_d, color2_q, color2_d, color3_q, color3_d;
  logic [PIXEL_WIDTH-1:0]  m_color_q, m_color_d;
  logic [USER_WIDTH-1:0]   user1_q, user1_d, user2_q, user2_d, user3_q, user3_d;
  logic [USER_WIDTH-1:0]   user4_q, user4_d, m_user_q, m_user_d;
  logic [RGB_W-1:0]        fog1_q, fog1_d, fog2_q, fog2_d, fog3_q, fog3_d;
  logic [FACTOR_WIDTH-1:0] a2_q, a2_d;
  logic signed [PROD_W-1:0] prod2_q, prod2_d;
  logic [W_W-1:0]          w3_q, w3_d;
  logic [CH_R:CH_B][BLEND_W-1:0] prod_c4_q, prod_c4_d, prod_f4_q, prod_f4_d;
  logic [SPW-1:0]          alpha4_q, alpha4_d;

  assign ce = !m_valid_q || m_ready;

  fog_lut #(
    .ADDR_WIDTH(LUT_SIZE_LOG2),
    .DATA_WIDTH(LUT_DATA_WIDTH)
  ) u_lut (
    .clk    (aclk),
    .wr_en  (lutWrValid),
    .wr_addr(lutWrAddr),
    .wr_data(lutWrData),
    .rd_en  (ce),
    .rd_addr(s_fogCoord[FOG_COORD_WIDTH-1 -: LUT_SIZE_LOG2]),
    .rd_data(lut_rd_data)
  );

  always_comb begin
    v1_d     = s_valid;
    frac1_d  = s_fogCoord[FRAC_W-1:0];
    color1_d = s_fragmentColor;
    user1_d  = s_user;
    en1_d    = confEnable;
    fog1_d   = confFogColor[PIXEL_WIDTH-1 -: RGB_W];
  end

  always_comb begin
    lut_a     = lut_rd_data[LUT_A_LSB +: FACTOR_WIDTH];
    lut_b     = lut_rd_data[LUT_B_LSB +: FACTOR_WIDTH];
    diff2     = $signed({{(PROD_W-FACTOR_WIDTH){1'b0}}, lut_b})
              - $signed({{(PROD_W-FACTOR_WIDTH){1'b0}}, lut_a});
    frac_ext2 = $signed({{(PROD_W-FRAC_W){1'b0}}, frac1_q});
    prod2_d   = diff2 * frac_ext2;
    a2_d      = lut_a;
    v2_d      = v1_q;
    color2_d  = color1_q;
    user2_d   = user1_q;
    en2_d     = en1_q;
    fog2_d    = fog1_q;
  end

  // Clamp on the upper byte only; the low factor bits never reach the weight.
  always_comb begin
    sum3 = $signed({{(PROD_W-FACTOR_WIDTH){1'b0}}, a2_q}) + (prod2_q >>> FRAC_W);
    if (sum3[PROD_W-1])                        f8_3 = '0;
    else if (|sum3[PROD_W-2:FACTOR_WIDTH])     f8_3 = '1;
    else                                       f8_3 = sum3[FACTOR_WIDTH-1 -: SPW];
    w3_d     = en2_q ? ({1'b0, f8_3} + W_W'(f8_3[SPW-1])) : W_UNITY;
    v3_d     = v2_q;
    color3_d = color2_q;
    user3_d  = user2_q;
    fog3_d   = fog2_q;
  end

  always_comb begin
    inv_w4    = W_UNITY - w3_q;
    prod_c4_d = '0;
    prod_f4_d = '0;
    for (int ch = CH_B; ch <= CH_R; ch++) begin
      prod_c4_d[ch] = BLEND_W'(color3_q[ch*SPW +: SPW]) * BLEND_W'(w3_q);
      prod_f4_d[ch] = BLEND_W'(fog3_q[(ch-1)*SPW +: SPW]) * BLEND_W'(inv_w4);
    end
    alpha4_d = color3_q[CH_A*SPW +: SPW];
    v4_d     = v3_q;
    user4_d  = user3_q;
  end

  always_comb begin
    blend5    = '0;
    m_color_d = '0;
    m_color_d[CH_A*SPW +: SPW] = alpha4_q;
    for (int ch = CH_B; ch <= CH_R; ch++) begin
      blend5[ch] = prod_c4_q[ch] + prod_f4_q[ch];
      m_color_d[ch*SPW +: SPW] = blend5[ch][SPW +: SPW];
    end
    m_valid_d = v4_q;
    m_user_d  = user4_q;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      v4_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_color_q <= '0;
      m_user_q  <= '0;
    end else if (ce) begin
      v1_q      <= v1_d;
      frac1_q   <= frac1_d;
      color1_q  <= color1_d;
      user1_q   <= user1_d;
      en1_q     <= en1_d;
      fog1_q    <= fog1_d;
      v2_q      <= v2_d;
      a2_q      <= a2_d;
      prod2_q   <= prod2_d;
      color2_q  <= color2_d;
      user2_q   <= user2_d;
      en2_q     <= en2_d;
      fog2_q    <= fog2_d;
      v3_q      <= v3_d;
      w3_q      <= w3_d;
      color3_q  <= color3_d;
      user3_q   <= user3_d;
      fog3_q    <= fog3_d;
      v4_q      <= v4_d;
      prod_c4_q <= prod_c4_d;
      prod_f4_q <= prod_f4_d;
      alpha4_q  <= alpha4_d;
      user4_q   <= user4_d;
      m_valid_q <= m_valid_d;
      m_color_q <= m_color_d;
      m_user_q  <= m_user_d;
    end
  end

  assign s_ready         = ce;
  assign m_valid         = m_valid_q;
  assign m_user          = m_user_q;
  assign m_fragmentColor = m_color_q;

  logic unused_bits;
  assign unused_bits = ^{confFogColor[SPW-1:0], sum3[FACTOR_WIDTH-SPW-1:0],
                         blend5[CH_R][BLEND_W-1], blend5[CH_R][SPW-1:0],
                         blend5[CH_G][BLEND_W-1], blend5[CH_G][SPW-1:0],
                         blend5[CH_B][BLEND_W-1], blend5[CH_B][SPW-1:0]};

endmodule

// File: tb/tb_fragment_fog_unit.sv
// Directed bench for fragment_fog_unit: reset, bypass, fog blend, LUT collision, backpressure.
module tb_fragment_fog_unit;

  logic        aclk = 1'b0;
  logic        reset;
  logic        confEnable;
  logic [31:0] confFogColor;
  logic        lutWrValid;
  logic [4:0]  lutWrAddr;
  logic [31:0] lutWrData;
  logic        s_valid;
  logic        s_ready;
  logic [0:0]  s_user;
  logic [31:0] s_fragmentColor;
  logic [15:0] s_fogCoord;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [0:0]  m_user;
  logic [31:0] m_fragmentColor;

  fragment_fog_unit dut (
    .aclk           (aclk),
    .reset          (reset),
    .confEnable     (confEnable),
    .confFogColor   (confFogColor),
    .lutWrValid     (lutWrValid),
    .lutWrAddr      (lutWrAddr),
    .lutWrData      (lutWrData),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_user         (s_user),
    .s_fragmentColor(s_fragmentColor),
    .s_fogCoord     (s_fogCoord),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_user         (m_user),
    .m_fragmentColor(m_fragmentColor)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        user;
    logic [31:0] color;
  } frag_t;

  typedef struct packed {
    logic        en;
    logic [31:0] fog;
    logic [31:0] color;
    logic [15:0] coord;
    logic [31:0] expv;
  } vec_t;

  frag_t exp_q[$];
  frag_t mon_exp;
  logic  rand_ready = 1'b0;
  logic  prev_stall = 1'b0;
  logic [31:0] prev_color;
  logic  prev_user;

  always @(posedge aclk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output scoreboard plus hold-while-stalled check.
  always @(negedge aclk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_color", m_fragmentColor, prev_color);
        check_eq("stall_user", m_user, prev_user);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_output", m_valid, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq("out_color", m_fragmentColor, mon_exp.color);
          check_eq("out_user", m_user, mon_exp.user);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_color = m_fragmentColor;
      prev_user  = m_user;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic send(input logic en, input logic [31:0] fog, input logic [31:0] color,
                      input logic [15:0] coord, input logic user);
    int   guard;
    logic acc;
    confEnable      = en;
    confFogColor    = fog;
    s_fragmentColor = color;
    s_fogCoord      = coord;
    s_user          = user;
    s_valid         = 1'b1;
    guard           = 0;
    while (1) begin
      @(negedge aclk);
      acc = s_ready;
      @(posedge aclk);
      #2;
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check_eq("send_timeout", guard, 0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic write_lut(input logic [4:0] addr, input logic [31:0] data);
    lutWrValid = 1'b1;
    lutWrAddr  = addr;
    lutWrData  = data;
    tick();
    lutWrValid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      tick();
      guard++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  vec_t vecs [9];
  int   lat;
  int   post_rst_valids;

  initial begin
    vecs = '{
      '{1'b1, 32'hFF0000AB, 32'h00FF0080, 16'h0000, 32'hFF000080},
      '{1'b1, 32'hFF0000AB, 32'h00FF0080, 16'hFFFF, 32'hFF000080},
      '{1'b1, 32'hFF0000AB, 32'h00FF0080, 16'h1234, 32'hFF000080},
      '{1'b1, 32'h00000055, 32'hC8C8C8FF, 16'h1C00, 32'h636363FF},
      '{1'b1, 32'h00000055, 32'hC8C8C8FF, 16'h1800, 32'hC8C8C8FF},
      '{1'b1, 32'h00000055, 32'hC8C8C8FF, 16'h1FFF, 32'h000000FF},
      '{1'b1, 32'h00804000, 32'h80FF0040, 16'h2800, 32'h40BF1F40},
      '{1'b0, 32'h00804000, 32'h80FF0040, 16'h2800, 32'h80FF0040},
      '{1'b1, 32'hFFFFFFFF, 32'h00000000, 16'h0400, 32'hFFFFFF00}
    };

    reset = 1'b1; s_valid = 1'b0; lutWrValid = 1'b0; lutWrAddr = '0; lutWrData = '0;
    confEnable = 1'b0; confFogColor = '0; s_fragmentColor = '0; s_fogCoord = '0; s_user = '0;
    repeat (3) @(posedge aclk);
    #2;
    reset = 1'b0;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_color", m_fragmentColor, 0);
    check_eq("rst_m_user", m_user, 0);
    check_eq("rst_s_ready", s_ready, 1);

    // Bypass and latency
    exp_q.push_back('{1'b1, 32'h12345678});
    send(1'b0, 32'hFFFFFFFF, 32'h12345678, 16'hABCD, 1'b1);
    lat = 1;
    while (!m_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("bypass_latency", lat, 5);
    drain();

    for (int i = 0; i < 32; i++) write_lut(5'(i), 32'h0);
    write_lut(5'd3, 32'hFFFF0000);
    write_lut(5'd5, 32'h80008000);

    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{1'(i), vecs[i].expv});
      send(vecs[i].en, vecs[i].fog, vecs[i].color, vecs[i].coord, 1'(i));
    end
    drain();

    // Entry 0 rewritten in the same cycle the first fragment reads it
    exp_q.push_back('{1'b0, 32'h00804040});
    exp_q.push_back('{1'b1, 32'h80FF0040});
    lutWrValid = 1'b1; lutWrAddr = 5'd0; lutWrData = 32'hFFFFFFFF;
    send(1'b1, 32'h00804000, 32'h80FF0040, 16'h0000, 1'b0);
    lutWrValid = 1'b0;
    send(1'b1, 32'h00804000, 32'h80FF0040, 16'h0000, 1'b1);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back('{1'(i), 32'h0A0B0C0D + 32'(i) * 32'h01010101});
      send(1'b0, 32'h0, 32'h0A0B0C0D + 32'(i) * 32'h01010101, 16'(i * 997), 1'(i));
    end
    drain();
    rand_ready = 1'b0;
    tick();
    tick();

    // Reset while three fragments are in flight
    for (int i = 0; i < 3; i++) send(1'b0, 32'h0, 32'hDEAD0000 + 32'(i), 16'h0, 1'b1);
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check_eq("midrst_m_valid", m_valid, 0);
    check_eq("midrst_m_color", m_fragmentColor, 0);
    check_eq("midrst_m_user", m_user, 0);
    tick();
    tick();
    reset = 1'b0;
    check_eq("postrst_s_ready", s_ready, 1);
    post_rst_valids = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (m_valid) post_rst_valids++;
    end
    check_eq("postrst_no_emission", post_rst_valids, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/fragment_fog_unit.md
# fragment_fog_unit

Per-fragment fog stage sitting directly downstream of the texture mapping unit: it consumes the textured fragment color stream and blends each fragment toward a configurable fog color. The fog factor comes from a piecewise-linear lookup table indexed by a normalized fog coordinate. Alpha passes through unmodified. The block is a fixed-latency, stallable valid/ready pipeline whose output feeds the per-fragment test/blend stages.

## Interface
- USER_WIDTH, 1, sideband carried alongside each fragment unchanged
- SUB_PIXEL_WIDTH, 8, bits per color channel; PIXEL_WIDTH = 4*SUB_PIXEL_WIDTH, channel order {R,G,B,A}, A in LSBs
- LUT_SIZE_LOG2, 5, log2 of LUT segment count; FRAC_WIDTH = 16 - LUT_SIZE_LOG2

Ports:
- aclk  in  1  clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- confEnable  in  1  1 = apply fog, 0 = pass color through bit-exact
- confFogColor  in  PIXEL_WIDTH  fog color; its alpha is ignored
- lutWrValid  in  1  LUT write strobe
- lutWrAddr  in  LUT_SIZE_LOG2  LUT entry index
- lutWrData  in  32  {[31:16] factor at segment start A, [15:0] factor at segment end B}, unsigned Q0.16
- s_valid / s_ready  in / out  1  input handshake
- s_user  in  USER_WIDTH  sideband
- s_fragmentColor  in  PIXEL_WIDTH  color from texture mapping unit
- s_fogCoord  in  16  unsigned normalized fog coordinate
- m_valid / m_ready  out / in  1  output handshake
- m_user  out  USER_WIDTH  sideband
- m_fragmentColor  out  PIXEL_WIDTH  fogged color

## Operation
- idx = s_fogCoord[15 -: LUT_SIZE_LOG2]; frac = s_fogCoord[FRAC_WIDTH-1:0].
- Interpolation: diff = B - A (17-bit signed); f16 = A + ((diff * frac) >>> FRAC_WIDTH); clamp to [0, 65535].
- f8 = f16[15 -: SUB_PIXEL_WIDTH]; weight w = f8 + f8[MSB] (range 0..256; f8 all-ones gives 256).
- Per R,G,B channel: out = (c*w + fog*(256 - w)) >> 8, unsigned, full-width products, no rounding term. A channel = input A.
- confEnable, confFogColor sampled per fragment in stage 1 and carried with it; mid-stream changes affect only fragments accepted afterward.
- confEnable = 0 forces w = 256 → output equals input exactly.
- LUT: LUT_SIZE entries, read-first. A write in cycle N is seen by fragments whose stage-1 read occurs in cycle N+1 or later; a same-cycle read of the same address returns old data. Writes accepted every cycle, independent of stalls.
- Reset clears all valid flags and output registers; LUT contents are not cleared (undefined until written).

## Timing
- Latency: 5 accepted-to-valid cycles with no stall. Stages: S1 LUT read + capture frac/color/user/conf; S2 diff*frac multiply; S3 add/clamp/weight; S4 channel multiplies; S5 sum/shift into output register.
- Throughput: one fragment per cycle.
- Stall: ce = !m_valid | m_ready; all stages advance together on ce; s_ready = ce (combinational from m_ready/m_valid, no other path).
- m_valid/m_user/m_fragmentColor held stable while m_valid & !m_ready.
- Bubbles are not collapsed; a stage holding invalid data still advances only on ce.
- Reset values: m_valid = 0, m_fragmentColor = 0, m_user = 0; s_ready = 1 the cycle after reset deasserts.
- Reset asserted mid-stream drops all in-flight fragments; no partial output.

## Structure
- Package fog_pkg: PIXEL_WIDTH derivation, channel index constants, LUT data field positions (A/B), FRAC_WIDTH function.
- Sub-module fog_lut: single-write/single-read synchronous RAM, read-first, one-cycle read latency, read enable = ce (holds output when stalled).
- Top: pipeline registers, interpolation, blend.

## Test plan
- Reset: assert reset 3 cycles mid-stream → m_valid=0, m_fragmentColor=0 next cycle; no post-reset emission of pre-reset fragments.
- Bypass: confEnable=0, color 0x12345678, any coord → 0x12345678 exactly 5 cycles after acceptance.
- Full fog: all LUT entries {0x0000,0x0000}, fog 0xFF000000, color 0x00FF0080 → 0xFF000080.
- Interpolation: entry 3 = {0xFFFF,0x0000}, coord 0x1C00 (idx 3, frac half) → f8=0x7F, w=127; color 0xC8C8C8FF, fog 0x000000xx → 0x636363FF.
- Backpressure: 20 back-to-back fragments, m_ready toggled pseudo-randomly → all 20 emitted in order, none dropped/duplicated, outputs stable while stalled.
- LUT collision: write entry 0 same cycle a fragment with idx 0 reaches S1 → that fragment uses old entry, next fragment uses new.
